// File: rtl/seq_mul_iter.sv
// Iterative shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per clock behind valid/ready handshakes.
// Optional two's-complement mode is enabled by defining SEQ_MUL_ITER_SIGNED_EN (adds the is_signed port).
module seq_mul_iter #(
    parameter int A_W            = 32,
    parameter int B_W            = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
`ifdef SEQ_MUL_ITER_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   y,
    output logic                 busy
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int W     = A_W + B_W;
    localparam int PPW   = A_W + BPC;
    localparam int STEPS = B_W / BPC;
    localparam int CW    = $clog2(STEPS + 1);

    if ((B_W % BPC) != 0 || A_W < 2 || B_W < 2) begin : g_bad_cfg
        $error("seq_mul_iter: BITS_PER_CYCLE must divide B_W, and A_W, B_W must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [A_W-1:0]  a_reg;
    logic [B_W-1:0]  b_reg;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic            sgn;

    logic            last;
    logic [BPC-1:0]  chunk;
    logic [PPW-1:0]  a_x;
    logic [PPW-1:0]  c_x;
    logic [PPW-1:0]  pp;
    logic [W-1:0]    acc_s;
    logic [W-1:0]    acc_n;

`ifndef SEQ_MUL_ITER_SIGNED_EN
    assign sgn = 1'b0;
`endif

    // The final chunk carries b's sign bit, so only there is the chunk treated as negative-weighted.
    always_comb begin
        last  = (cnt == CW'(STEPS - 1));
        chunk = b_reg[BPC-1:0];
        a_x   = {{BPC{sgn & a_reg[A_W-1]}}, a_reg};
        c_x   = {{A_W{sgn & last & chunk[BPC-1]}}, chunk};
        pp    = a_x * c_x;
        acc_s = sgn ? W'($signed(acc) >>> BPC) : (acc >> BPC);
        acc_n = acc_s + (W'(pp) << (B_W - BPC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            y         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
`ifdef SEQ_MUL_ITER_SIGNED_EN
            sgn       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        acc      <= '0;
                        cnt      <= '0;
`ifdef SEQ_MUL_ITER_SIGNED_EN
                        sgn      <= is_signed;
`endif
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= acc_n;
                    b_reg <= b_reg >> BPC;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state     <= DONE;
                        y         <= acc_n;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_iter.sv
// Randomised bench for seq_mul_iter: two instances (1 and 4 bits per cycle) checked against an arithmetic model.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid holds until then.
module tb_seq_mul_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        out_ready;
    logic        is_signed;
    logic [31:0] a;
    logic [7:0]  b;
    int          dsel;

    logic        iv1, iv4, or1, or4;
    logic        ir1, ir4, ov1, ov4, busy1, busy4;
    logic [39:0] y1, y4;

    logic [39:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        iv1 = in_valid && (dsel == 0);
        iv4 = in_valid && (dsel == 1);
        or1 = out_ready && (dsel == 0);
        or4 = out_ready && (dsel == 1);
    end

    seq_mul_iter #(.A_W(32), .B_W(8), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
`ifdef SEQ_MUL_ITER_SIGNED_EN
        .is_signed(is_signed),
`endif
        .out_valid(ov1), .out_ready(or1), .y(y1), .busy(busy1)
    );

    seq_mul_iter #(.A_W(32), .B_W(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
`ifdef SEQ_MUL_ITER_SIGNED_EN
        .is_signed(is_signed),
`endif
        .out_valid(ov4), .out_ready(or4), .y(y4), .busy(busy4)
    );

    function automatic logic cur_ir();   return dsel == 1 ? ir4 : ir1;     endfunction
    function automatic logic cur_ov();   return dsel == 1 ? ov4 : ov1;     endfunction
    function automatic logic cur_busy(); return dsel == 1 ? busy4 : busy1; endfunction
    function automatic logic [39:0] cur_y(); return dsel == 1 ? y4 : y1;   endfunction

    // Reference: widen both operands to 64 bits (sign- or zero-extended) and keep the low 40 bits.
    function automatic logic [39:0] ref_mul(input logic [31:0] av, input logic [7:0] bv, input logic sg);
        logic [63:0] pa, pb, p;
        pa = sg ? {{32{av[31]}}, av} : {32'b0, av};
        pb = sg ? {{56{bv[7]}}, bv} : {56'b0, bv};
        p  = pa * pb;
        return p[39:0];
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input int sel, input logic [31:0] av, input logic [7:0] bv,
                          input logic sg, input int hold, input bit spam);
        logic [39:0] exp_y;
        int lat;
        int steps;
        dsel  = sel;
        steps = (sel == 1) ? 2 : 8;
        lat = 0;
        while (!cur_ir() && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check_val("in_ready_idle", cur_ir(), 1);
        a = av; b = bv; is_signed = sg; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        exp_q.push_back(ref_mul(av, bv, sg));
        if (spam) begin a = $urandom; b = 8'($urandom); end
        else in_valid = 1'b0;
        check_val("in_ready_run", cur_ir(), 0);
        lat = 0;
        while (!cur_ov() && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (spam) begin a = $urandom; b = 8'($urandom); end
        end
        in_valid = 1'b0;
        exp_y = exp_q.pop_front();
        check_val("latency", lat, steps);
        if (!cur_ov()) begin
            out_ready = 1'b0;
            return;
        end
        check_val("busy_done", cur_busy(), 1);
        check_val("in_ready_done", cur_ir(), 0);
        check_val("y", cur_y(), exp_y);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", cur_ov(), 1);
            check_val("hold_y", cur_y(), exp_y);
            check_val("hold_in_ready", cur_ir(), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("valid_drop", cur_ov(), 0);
        check_val("back_to_idle", cur_ir(), 1);
        check_val("busy_clear", cur_busy(), 0);
        check_val("y_retained", cur_y(), exp_y);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic rsg;
        int   seen;
        in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
        a = '0; b = '0; dsel = 0;

        @(posedge clk); #1;
        check_val("rst_in_ready1", ir1, 1);
        check_val("rst_out_valid1", ov1, 0);
        check_val("rst_busy1", busy1, 0);
        check_val("rst_y1", y1, 0);
        check_val("rst_in_ready4", ir4, 1);
        check_val("rst_y4", y4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 32'hFFFF_FFFF, 8'hFF, 1'b0, 0, 1'b0);
        run_op(0, 32'h0000_1234, 8'h00, 1'b0, 0, 1'b0);
        run_op(0, 32'h0000_0000, 8'h5A, 1'b0, 0, 1'b0);
        run_op(0, 32'd1000, 8'd200, 1'b0, 5, 1'b0);
        run_op(1, 32'h8000_0001, 8'hF0, 1'b0, 0, 1'b0);
        run_op(1, 32'hFFFF_FFFF, 8'hFF, 1'b0, 2, 1'b0);
        run_op(0, 32'hDEAD_BEEF, 8'h9C, 1'b0, 1, 1'b1);

        // Abort: three steps into RUN, pull reset and confirm nothing comes out.
        dsel = 0;
        a = 32'd123; b = 8'd45; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_out_valid", ov1, 0);
        check_val("abort_in_ready", ir1, 1);
        check_val("abort_busy", busy1, 0);
        check_val("abort_y", y1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov1) seen = 1;
        end
        check_val("abort_no_output", seen, 0);
        run_op(0, 32'd7, 8'd6, 1'b0, 0, 1'b0);

`ifdef SEQ_MUL_ITER_SIGNED_EN
        run_op(0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(0, 32'h8000_0000, 8'h7F, 1'b1, 0, 1'b0);
        run_op(0, 32'hFFFF_FFFF, 8'hFF, 1'b0, 0, 1'b0);
        run_op(1, 32'h8000_0000, 8'h80, 1'b1, 0, 1'b0);
        run_op(1, 32'h0000_0003, 8'hFB, 1'b1, 1, 1'b0);
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef SEQ_MUL_ITER_SIGNED_EN
            rsg = 1'($urandom_range(0, 1));
`else
            rsg = 1'b0;
`endif
            run_op(int'($urandom_range(0, 1)), $urandom, 8'($urandom_range(0, 255)), rsg,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mul_iter.md
Name: seq_mul_iter

Overview:
- Parametrised, multi-cycle shift-add multiplier. Produces the full A_W+B_W-bit product of A (A_W bits) and B (B_W bits).
- Successor to the team's combinational 32x8 array multiplier. Replaces the unrolled row array with one reusable adder row, iterated BITS_PER_CYCLE multiplier bits per clock.
- Has valid/ready handshakes on input and output, so it sits between pipeline stages of the datapath and can absorb backpressure.

Parameters:
- A_W, 32, multiplicand width (>=2).
- B_W, 8, multiplier width (>=2).
- BITS_PER_CYCLE, 1, multiplier bits retired per clock. Must divide B_W exactly; otherwise elaboration fails with $error.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  A_W  multiplicand.
- b  input  B_W  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- y  output  A_W+B_W  product.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous on rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, all internal registers 0.
- Reset asserted mid-operation discards the operation. No output is produced for it.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a and b, clear accumulator, step count=0, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - take the low BITS_PER_CYCLE bits of the B shift register;
    - add a*chunk (A_W+BITS_PER_CYCLE bits) into the accumulator's upper A_W+BITS_PER_CYCLE bits;
    - shift accumulator and B register right by BITS_PER_CYCLE;
    - increment step count.
    - After the STEPS=B_W/BITS_PER_CYCLE-th step, go to DONE.
  - DONE: out_valid=1, y=accumulator. y is held stable while out_valid&!out_ready. On out_ready, go to IDLE.
- Latency:
  - Input handshake at edge T. out_valid rises after edge T+STEPS.
  - Default config: 8 cycles.
  - Throughput: one product per STEPS+2 cycles with no backpressure (IDLE accept cycle + STEPS + DONE).
- in_ready is 0 in RUN and DONE. in_valid asserted there is ignored, and no operand is overwritten.
- Unsigned arithmetic by default. No truncation: the accumulator is A_W+B_W bits, and the carry-out of each step is retained in the accumulator MSB.
- y reads 0 in IDLE after reset. After a completed transfer, y retains the last product until the next DONE.
- a=0 or b=0 still runs the full STEPS cycles. There is no early termination.
- Step count width is clog2(STEPS+1). The count never wraps, because the FSM leaves RUN at STEPS.

Optional Feature:
- Macro: SEQ_MUL_ITER_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled at input handshake.
  - When 1, a and b are two's complement:
    - the partial product is a sign-extended;
    - the final step, which contains the b MSB, subtracts the weight of b[B_W-1] (adds its two's complement) instead of adding it;
    - the accumulator shift is arithmetic.
  - y is the signed A_W+B_W-bit product.
  - When 0, behaviour is identical to the unsigned mode.
- Undefined: port is_signed is absent and the block is unsigned only. Latency is identical in both builds.

Test Plan:
- Default params, a=32'hFFFF_FFFF, b=8'hFF, out_ready=1 -> y=40'hFE_FFFF_FF01; out_valid rises 8 cycles after the accept edge, for exactly 1 cycle.
- a=32'h0000_1234, b=8'h00, then a=0, b=8'h5A -> y=40'h0 both times; full 8-cycle latency each time.
- Backpressure: a=32'd1000, b=8'd200, out_ready=0 for 5 cycles after out_valid -> y=40'd200000 held stable, in_ready=0 throughout; returns to IDLE one cycle after out_ready=1.
- BITS_PER_CYCLE=4, a=32'h8000_0001, b=8'hF0 -> y=40'h78_0000_00F0; latency 2 cycles.
- Drop rst_n low in RUN at step 3, release, then issue a=32'd7, b=8'd6 -> no out_valid for the aborted operation; next y=40'd42.
- SEQ_MUL_ITER_SIGNED_EN, is_signed=1:
  - a=32'hFFFF_FFFF, b=8'hFF -> y=40'h00_0000_0001;
  - a=32'h8000_0000, b=8'h7F -> y=40'hC0_8000_0000;
  - is_signed=0 with a=32'hFFFF_FFFF, b=8'hFF -> y=40'hFE_FFFF_FF01.
